// File: rtl/rf_pkg.sv
// Shared constants and helpers for the register file and its busy scoreboard.
package rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  function automatic logic is_zero_reg(input logic [31:0] addr, input logic zero_reg);
    return zero_reg && (addr == 32'd0);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on accepted issue, cleared on writeback or flush,
// with the issue handshake and a registered count of pending registers.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        WriteAddr,
  input  logic                     IssueValid,
  input  logic [ADDR_W-1:0]        IssueAddr,
  input  logic                     Flush,
  output logic                     IssueReady,
  output logic [(1<<ADDR_W)-1:0]   Busy,
  output logic [ADDR_W:0]          PendingCount
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             wr_eff, iss_zero, retire_iss, issue_ok, issue_set, inc, dec;

  always_comb begin
    wr_eff     = RegWrite & ~is_zero_reg(32'(WriteAddr), ZERO_REG != 0);
    iss_zero   = is_zero_reg(32'(IssueAddr), ZERO_REG != 0);
    retire_iss = RegWrite & (WriteAddr == IssueAddr);
    // A pending destination may be reissued only in the cycle it retires.
    issue_ok   = ~Flush & (iss_zero | ~(busy_q[IssueAddr] & ~retire_iss));
    issue_set  = IssueValid & issue_ok & ~iss_zero;
    inc        = issue_set & ~busy_q[IssueAddr];
    dec        = wr_eff & busy_q[WriteAddr] & ~(issue_set & (WriteAddr == IssueAddr));

    busy_d = busy_q;
    if (wr_eff)    busy_d[WriteAddr] = 1'b0;
    if (issue_set) busy_d[IssueAddr] = 1'b1;
    if (Flush)     busy_d = '0;

    cnt_d = cnt_q;
    if (Flush)            cnt_d = '0;
    else if (inc && !dec) cnt_d = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    else if (dec && !inc) cnt_d = cnt_q - {{ADDR_W{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign IssueReady   = issue_ok;
  assign Busy         = busy_q;
  assign PendingCount = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with optional hardwired zero register,
// optional write-to-read bypass and a busy scoreboard for hazard detection.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              ReadBusy1,
  output logic              ReadBusy2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueAddr,
  output logic              IssueReady,
  input  logic              Flush,
  output logic [ADDR_W:0]   PendingCount
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_eff;
  logic [ADDR_W-1:0] ra      [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              rd_busy [2];

  assign wr_eff = RegWrite & ~is_zero_reg(32'(WriteAddr), ZERO_REG != 0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_eff) begin
      regs_q[WriteAddr] <= WriteData;
    end
  end

  assign ra[0] = ReadAddr1;
  assign ra[1] = ReadAddr2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs_q[ra[p]];
      rd_busy[p] = busy[ra[p]];
      // Forwarding the retiring value also hides the busy bit it is about to clear.
      if ((BYPASS != 0) && wr_eff && (WriteAddr == ra[p])) begin
        rd_data[p] = WriteData;
        rd_busy[p] = 1'b0;
      end
      if (is_zero_reg(32'(ra[p]), ZERO_REG != 0)) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign ReadData1 = rd_data[0];
  assign ReadData2 = rd_data[1];
  assign ReadBusy1 = rd_busy[0];
  assign ReadBusy2 = rd_busy[1];

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk          (clk),
    .reset        (reset),
    .RegWrite     (RegWrite),
    .WriteAddr    (WriteAddr),
    .IssueValid   (IssueValid),
    .IssueAddr    (IssueAddr),
    .Flush        (Flush),
    .IssueReady   (IssueReady),
    .Busy         (busy),
    .PendingCount (PendingCount)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed checks of the register file / scoreboard with bypass on and off.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        reset;
  logic [4:0]  ReadAddr1, ReadAddr2, WriteAddr, IssueAddr;
  logic        RegWrite, IssueValid, Flush;
  logic [31:0] WriteData;

  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        rb1, rb2, nb_rb1, nb_rb2, iss_rdy, nb_iss_rdy;
  logic [5:0]  pcnt, nb_pcnt;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(rd1), .ReadData2(rd2),
    .ReadBusy1(rb1), .ReadBusy2(rb2),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .IssueValid(IssueValid), .IssueAddr(IssueAddr), .IssueReady(iss_rdy),
    .Flush(Flush), .PendingCount(pcnt)
  );

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset),
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(nb_rd1), .ReadData2(nb_rd2),
    .ReadBusy1(nb_rb1), .ReadBusy2(nb_rb2),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .IssueValid(IssueValid), .IssueAddr(IssueAddr), .IssueReady(nb_iss_rdy),
    .Flush(Flush), .PendingCount(nb_pcnt)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite = 1'b0; IssueValid = 1'b0; Flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ReadAddr1 = '0; ReadAddr2 = '0; WriteAddr = '0; IssueAddr = '0;
    WriteData = '0;
    idle();

    // Reset with clock stopped
    #2;
    ReadAddr1 = 5'd5; ReadAddr2 = 5'd7; IssueAddr = 5'd7;
    #1;
    chk("rst_rd1", rd1, 32'h0);
    chk("rst_rd2", rd2, 32'h0);
    chk("rst_busy1", rb1, 1'b0);
    chk("rst_cnt", pcnt, 6'd0);
    chk("rst_issue_ready", iss_rdy, 1'b1);
    reset = 1'b0;
    #2;
    clk_run = 1'b1;
    tick();

    // Write r5, bypass vs. no bypass
    RegWrite = 1'b1; WriteAddr = 5'd5; WriteData = 32'hDEADBEEF; ReadAddr1 = 5'd5;
    #1;
    chk("byp_same_cycle", rd1, 32'hDEADBEEF);
    chk("nobyp_same_cycle", nb_rd1, 32'h0);
    tick();
    idle();
    #1;
    chk("byp_next_cycle", rd1, 32'hDEADBEEF);
    chk("nobyp_next_cycle", nb_rd1, 32'hDEADBEEF);

    // Zero register: write and issue both ignored
    RegWrite = 1'b1; WriteAddr = 5'd0; WriteData = 32'h1234;
    IssueValid = 1'b1; IssueAddr = 5'd0; ReadAddr1 = 5'd0;
    #1;
    chk("r0_bypass_blocked", rd1, 32'h0);
    chk("r0_issue_ready", iss_rdy, 1'b1);
    tick();
    idle();
    #1;
    chk("r0_data", rd1, 32'h0);
    chk("r0_busy", rb1, 1'b0);
    chk("r0_cnt", pcnt, 6'd0);

    // Issue r7, then WAW attempt
    IssueValid = 1'b1; IssueAddr = 5'd7; ReadAddr1 = 5'd7;
    #1;
    chk("r7_issue_ready", iss_rdy, 1'b1);
    tick();
    #1;
    chk("r7_busy", rb1, 1'b1);
    chk("r7_cnt", pcnt, 6'd1);
    chk("r7_waw_blocked", iss_rdy, 1'b0);
    tick();
    idle();
    #1;
    chk("r7_cnt_after_block", pcnt, 6'd1);

    // Writeback r7
    RegWrite = 1'b1; WriteAddr = 5'd7; WriteData = 32'h77;
    #1;
    chk("r7_wb_byp_busy", rb1, 1'b0);
    chk("r7_wb_nobyp_busy", nb_rb1, 1'b1);
    tick();
    idle();
    #1;
    chk("r7_cleared_busy", rb1, 1'b0);
    chk("r7_cleared_cnt", pcnt, 6'd0);
    chk("r7_data", rd1, 32'h77);

    // Same-cycle retire and reissue of r9
    IssueValid = 1'b1; IssueAddr = 5'd9;
    tick();
    idle();
    RegWrite = 1'b1; WriteAddr = 5'd9; WriteData = 32'd5;
    IssueValid = 1'b1; IssueAddr = 5'd9;
    #1;
    chk("r9_pre_cnt", pcnt, 6'd1);
    chk("r9_collide_ready", iss_rdy, 1'b1);
    tick();
    idle();
    ReadAddr1 = 5'd9;
    #1;
    chk("r9_data", rd1, 32'd5);
    chk("r9_busy", rb1, 1'b1);
    chk("r9_cnt", pcnt, 6'd1);

    // Retire r3 while issuing r4
    IssueValid = 1'b1; IssueAddr = 5'd3;
    tick();
    idle();
    #1;
    chk("r3_cnt", pcnt, 6'd2);
    RegWrite = 1'b1; WriteAddr = 5'd3; WriteData = 32'h33;
    IssueValid = 1'b1; IssueAddr = 5'd4;
    tick();
    idle();
    ReadAddr1 = 5'd3; ReadAddr2 = 5'd4;
    #1;
    chk("r3r4_cnt", pcnt, 6'd2);
    chk("r3_busy", rb1, 1'b0);
    chk("r4_busy", rb2, 1'b1);

    // Fill and flush; issue and write during the flush cycle
    for (int r = 1; r <= 3; r++) begin
      IssueValid = 1'b1; IssueAddr = 5'(r);
      tick();
    end
    idle();
    #1;
    chk("pre_flush_cnt", pcnt, 6'd5);
    Flush = 1'b1; IssueValid = 1'b1; IssueAddr = 5'd10;
    RegWrite = 1'b1; WriteAddr = 5'd11; WriteData = 32'hAA;
    #1;
    chk("flush_issue_ready", iss_rdy, 1'b0);
    tick();
    idle();
    ReadAddr1 = 5'd10; ReadAddr2 = 5'd1; IssueAddr = 5'd9;
    #1;
    chk("flush_cnt", pcnt, 6'd0);
    chk("flush_r10_busy", rb1, 1'b0);
    chk("flush_r1_busy", rb2, 1'b0);
    chk("flush_r9_ready", iss_rdy, 1'b1);
    ReadAddr1 = 5'd11;
    #1;
    chk("flush_write_data", rd1, 32'hAA);

    // Async reset between edges
    IssueValid = 1'b1; IssueAddr = 5'd12;
    tick();
    idle();
    #1;
    chk("pre_areset_cnt", pcnt, 6'd1);
    ReadAddr1 = 5'd5; ReadAddr2 = 5'd12;
    #1;
    reset = 1'b1;
    #1;
    chk("areset_cnt", pcnt, 6'd0);
    chk("areset_data", rd1, 32'h0);
    chk("areset_busy", rb2, 1'b0);
    chk("areset_nobyp_data", nb_rd1, 32'h0);
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
